// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// forwarding mux selects and the ResultSrc code that identifies a load.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Newest producer wins: M holds a younger result than W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
    if (we_m && rd_m != 5'd0 && rd_m == rs)      return FWD_M;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) return FWD_W;
    else                                         return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (sclr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipe: forwarding, load-use
// stalls, branch flushes, memory-wait freeze with timeout trap, perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter logic [1:0] LOAD_SRC = RESULT_LOAD,
  parameter int         TIMEOUT  = 16,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             Fault,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_W = WW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          mem_stall, lw_stall;

  assign mem_stall = MemReqM & ~MemReadyM;
  assign lw_stall  = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    ForwardAE = sclr ? FWD_RF : fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = sclr ? FWD_RF : fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushW = 1'b0;
    if (sclr) begin
      FlushD = 1'b1; FlushE = 1'b1; FlushW = 1'b1;
    end else if (state_q == ST_FAULT || mem_stall) begin
      // Whole pipe frozen; only the writeback side is bubbled.
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1; FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: if (mem_stall) begin
        state_d = ST_WAIT;
        wait_d  = WW'(1);
      end
      ST_WAIT: begin
        if (!MemReqM || MemReadyM) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == TO_W) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign Fault = (state_q == ST_FAULT);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk), .sclr(sclr), .inc(StallF & ~sclr), .q(StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk), .sclr(sclr), .inc(FlushE & ~sclr), .q(FlushCnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=4, CNT_W=4.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       sclr;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Fault;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] StallCnt, FlushCnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_SRC(2'b01), .TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .sclr(sclr),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Fault(Fault),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Control outputs packed as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic int ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    sclr = 1'b1; tick(); sclr = 1'b0; settle();
  endtask

  initial begin
    sclr = 1'b1;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 0;
    tick(); tick();
    chk("rst_ctl", ctl(), 7'b0000111);
    chk("rst_fault", Fault, 0);
    chk("rst_scnt", StallCnt, 0);
    chk("rst_fcnt", FlushCnt, 0);
    RegWriteM = 1; RdM = 5; Rs1E = 5;
    chk("rst_fwd", ForwardAE, 0);
    sclr = 1'b0; settle();

    // forwarding
    RegWriteW = 1; RdW = 5; settle();
    chk("fwdA_M", ForwardAE, 2);
    chk("fwdB_none", ForwardBE, 0);
    RegWriteM = 0; settle();
    chk("fwdA_W", ForwardAE, 1);
    RegWriteM = 1; RdM = 0; RdW = 0; settle();
    chk("fwdA_x0", ForwardAE, 0);
    RdW = 9; Rs2E = 9; settle();
    chk("fwdB_W", ForwardBE, 1);
    RegWriteM = 0; RegWriteW = 0; RdW = 0; Rs1E = 0; Rs2E = 0; settle();

    // load-use stall
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; settle();
    chk("lw_ctl", ctl(), 7'b1100010);
    tick();
    chk("lw_scnt", StallCnt, 1);
    chk("lw_fcnt", FlushCnt, 1);
    RdE = 0; settle();
    chk("lw_x0_ctl", ctl(), 0);
    tick();
    chk("lw_x0_scnt", StallCnt, 1);

    // branch beats load-use
    RdE = 7; PCSrcE = 1; settle();
    chk("br_ctl", ctl(), 7'b0000110);
    tick();
    chk("br_fcnt", FlushCnt, 2);
    chk("br_scnt", StallCnt, 1);
    PCSrcE = 0; ResultSrcE = 0; RdE = 0; Rs2D = 0;
    do_reset();
    chk("clr_scnt", StallCnt, 0);

    // memory wait: 3 stall cycles, branch held off until release
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("mw_ctl%0d", i), ctl(), 7'b1111001);
      tick();
    end
    MemReadyM = 1; settle();
    chk("mw_rel_ctl", ctl(), 7'b0000110);
    tick();
    chk("mw_scnt", StallCnt, 3);
    chk("mw_fcnt", FlushCnt, 1);
    chk("mw_fault", Fault, 0);
    MemReqM = 0; MemReadyM = 0; PCSrcE = 0;
    do_reset();

    // timeout -> fault
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("to_nofault4", Fault, 0);
    tick();
    chk("to_fault5", Fault, 1);
    MemReqM = 0; PCSrcE = 1; settle();
    chk("to_frozen", ctl(), 7'b1111001);
    tick();
    chk("to_sticky", Fault, 1);
    chk("to_scnt", StallCnt, 6);
    PCSrcE = 0;
    do_reset();
    chk("to_clr_fault", Fault, 0);
    chk("to_clr_scnt", StallCnt, 0);
    chk("to_clr_fcnt", FlushCnt, 0);

    // ready on the last allowed wait cycle releases without fault
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) tick();
    MemReadyM = 1; settle();
    chk("edge_rel_ctl", ctl(), 0);
    tick();
    MemReqM = 0; MemReadyM = 0;
    tick();
    chk("edge_nofault", Fault, 0);
    do_reset();

    // saturation: 2^4+5 stall cycles
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_scnt14", StallCnt, 14);
    for (int i = 0; i < 7; i++) tick();
    chk("sat_scnt", StallCnt, 15);
    chk("sat_fcnt", FlushCnt, 15);
    ResultSrcE = 0; RdE = 0; Rs1D = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
